// File: rtl/window_sad_matcher.sv
// Window SAD matcher: scores each 16x16 window from the window handler
// against an internal 16x16 template and keeps the best (lowest SAD) match
// and its (x, y) position over one scan.
module window_sad_matcher (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [15:0][15:0][7:0]  window_data,
  input  logic                    window_ready,
  input  logic                    done,
  input  logic                    tmpl_we,
  input  logic [5:0]              tmpl_addr,
  input  logic [31:0]             tmpl_data,
  output logic                    receive,
  output logic                    busy,
  output logic                    result_valid,
  input  logic                    result_ack,
  output logic [15:0]             best_sad,
  output logic [6:0]              best_x,
  output logic [6:0]              best_y
);

  localparam int DATA_W = 8;
  localparam int COEF_W = 8;
  localparam int ROW_W  = 12;
  localparam int SUM_W  = 16;
  localparam int POS_W  = 7;
  localparam logic [POS_W-1:0] POS_MAX = 7'd64;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, REPORT} state_t;

  state_t state_q, state_d;
  logic   drain_cnt;

  logic [15:0][15:0][COEF_W-1:0] tmpl;

  logic [POS_W-1:0] x_cnt, y_cnt;
  logic             found;
  logic             accept, scan_go;

  logic [15:0][ROW_W-1:0] row_sum_c;
  logic [15:0][ROW_W-1:0] row_sum_p0;
  logic [POS_W-1:0]       x_p0, y_p0;
  logic                   vld_p0;

  logic [SUM_W-1:0] total_c;
  logic [SUM_W-1:0] total_p1;
  logic [POS_W-1:0] x_p1, y_p1;
  logic             vld_p1;

  // Absolute difference of two unsigned pixels, zero-extended into a signed
  // difference so the sign bit selects the negation.
  function automatic logic [DATA_W-1:0] abs_diff(input logic [DATA_W-1:0] a,
                                                 input logic [COEF_W-1:0] b);
    logic signed [DATA_W:0] d;
    logic signed [DATA_W:0] n;
    d = $signed({1'b0, a}) - $signed({1'b0, b});
    n = -d;
    return d[DATA_W] ? n[DATA_W-1:0] : d[DATA_W-1:0];
  endfunction

  // Sum of 16 absolute differences across one row; 12 bits cannot overflow.
  function automatic logic [ROW_W-1:0] row_sad(input logic [15:0][DATA_W-1:0] w,
                                               input logic [15:0][COEF_W-1:0] t);
    logic [ROW_W-1:0] acc;
    acc = '0;
    for (int c = 0; c < 16; c++) begin
      acc = acc + {{(ROW_W-DATA_W){1'b0}}, abs_diff(w[c], t[c])};
    end
    return acc;
  endfunction

  assign scan_go      = (state_q == IDLE) && start;
  assign accept       = (state_q == RUN) && window_ready;
  assign busy         = (state_q == RUN) || (state_q == DRAIN);
  assign result_valid = (state_q == REPORT);

  // State register and DRAIN cycle counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      drain_cnt <= 1'b0;
    end else begin
      state_q   <= state_d;
      drain_cnt <= (state_q == DRAIN) ? ~drain_cnt : 1'b0;
    end
  end

  // Next-state logic: DRAIN is held two cycles to flush the S1/S2 stages.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start)      state_d = RUN;
      RUN:     if (done)       state_d = DRAIN;
      DRAIN:   if (drain_cnt)  state_d = REPORT;
      REPORT:  if (result_ack) state_d = IDLE;
      default:                 state_d = IDLE;
    endcase
  end

  // Template store, writable only while idle; deliberately not reset.
  always_ff @(posedge clk) begin
    if ((state_q == IDLE) && tmpl_we) begin
      tmpl[tmpl_addr[5:2]][{tmpl_addr[1:0], 2'd0}] <= tmpl_data[7:0];
      tmpl[tmpl_addr[5:2]][{tmpl_addr[1:0], 2'd1}] <= tmpl_data[15:8];
      tmpl[tmpl_addr[5:2]][{tmpl_addr[1:0], 2'd2}] <= tmpl_data[23:16];
      tmpl[tmpl_addr[5:2]][{tmpl_addr[1:0], 2'd3}] <= tmpl_data[31:24];
    end
  end

  // Raster position of the next accepted window, plus the accept acknowledge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x_cnt   <= '0;
      y_cnt   <= '0;
      receive <= 1'b0;
    end else begin
      receive <= accept;
      if (scan_go) begin
        x_cnt <= '0;
        y_cnt <= '0;
      end else if (accept) begin
        if (x_cnt == POS_MAX) begin
          x_cnt <= '0;
          y_cnt <= (y_cnt == POS_MAX) ? '0 : y_cnt + 7'd1;
        end else begin
          x_cnt <= x_cnt + 7'd1;
        end
      end
    end
  end

  // ---- S1: per-row SAD ----
  always_comb begin
    row_sum_c = '0;
    for (int r = 0; r < 16; r++) begin
      row_sum_c[r] = row_sad(window_data[r], tmpl[r]);
    end
  end

  // S1 data registers.
  always_ff @(posedge clk) begin
    row_sum_p0 <= row_sum_c;
    x_p0       <= x_cnt;
    y_p0       <= y_cnt;
  end

  // S1 valid.
  always_ff @(posedge clk) begin
    if (!rst_n) vld_p0 <= 1'b0;
    else        vld_p0 <= accept;
  end

  // ---- S2: window total ----
  always_comb begin
    total_c = '0;
    for (int r = 0; r < 16; r++) begin
      total_c = total_c + {{(SUM_W-ROW_W){1'b0}}, row_sum_p0[r]};
    end
  end

  // S2 data registers.
  always_ff @(posedge clk) begin
    total_p1 <= total_c;
    x_p1     <= x_p0;
    y_p1     <= y_p0;
  end

  // S2 valid.
  always_ff @(posedge clk) begin
    if (!rst_n) vld_p1 <= 1'b0;
    else        vld_p1 <= vld_p0;
  end

  // ---- S3: best-match tracking; strict less-than keeps the earliest tie ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      best_sad <= 16'hFFFF;
      best_x   <= '0;
      best_y   <= '0;
      found    <= 1'b0;
    end else if (scan_go) begin
      best_sad <= 16'hFFFF;
      best_x   <= '0;
      best_y   <= '0;
      found    <= 1'b0;
    end else if (vld_p1 && (!found || (total_p1 < best_sad))) begin
      best_sad <= total_p1;
      best_x   <= x_p1;
      best_y   <= y_p1;
      found    <= 1'b1;
    end
  end

endmodule

// File: tb/tb_window_sad_matcher.sv
// Scoreboard bench for window_sad_matcher: a reference model computes the
// expected best match for every scan and queues it; the entry is popped and
// compared when the DUT raises result_valid.
module tb_window_sad_matcher;

  typedef struct packed {
    logic [15:0] sad;
    logic [6:0]  x;
    logic [6:0]  y;
  } res_t;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   start;
  logic [15:0][15:0][7:0] window_data;
  logic                   window_ready;
  logic                   done;
  logic                   tmpl_we;
  logic [5:0]             tmpl_addr;
  logic [31:0]            tmpl_data;
  logic                   receive;
  logic                   busy;
  logic                   result_valid;
  logic                   result_ack;
  logic [15:0]            best_sad;
  logic [6:0]             best_x;
  logic [6:0]             best_y;

  res_t       exp_q[$];
  logic [7:0] win_q[$];
  bit         ramp_mode;
  logic [7:0] tmpl_m [16][16];
  int         checks = 0;
  int         errors = 0;
  int         rx_total = 0;

  always #5 clk = ~clk;

  window_sad_matcher dut (
    .clk(clk), .rst_n(rst_n), .start(start), .window_data(window_data),
    .window_ready(window_ready), .done(done), .tmpl_we(tmpl_we),
    .tmpl_addr(tmpl_addr), .tmpl_data(tmpl_data), .receive(receive),
    .busy(busy), .result_valid(result_valid), .result_ack(result_ack),
    .best_sad(best_sad), .best_x(best_x), .best_y(best_y)
  );

  always @(negedge clk) if (receive === 1'b1) rx_total++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0][15:0][7:0] make_win(input logic [7:0] v, input bit ramp);
    logic [15:0][15:0][7:0] w;
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++)
        w[r][c] = (ramp ? 8'(r * 16 + c) : 8'd0) + v;
    return w;
  endfunction

  function automatic int sad_model(input logic [15:0][15:0][7:0] w);
    int s = 0;
    int d;
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++) begin
        d = int'(w[r][c]) - int'(tmpl_m[r][c]);
        s += (d < 0) ? -d : d;
      end
    return s;
  endfunction

  task automatic write_tmpl(input bit ramp, input logic [7:0] v);
    logic [7:0] b;
    for (int a = 0; a < 64; a++) begin
      for (int k = 0; k < 4; k++) begin
        b = (ramp ? 8'((a / 4) * 16 + 4 * (a % 4) + k) : 8'd0) + v;
        tmpl_m[a / 4][4 * (a % 4) + k] = b;
        tmpl_data[8 * k +: 8] = b;
      end
      tmpl_addr = 6'(a);
      tmpl_we   = 1'b1;
      tick();
    end
    tmpl_we   = 1'b0;
    tmpl_data = '0;
  endtask

  // Queue the model's expected result, then run one scan on the DUT and
  // return what it reports (no comparisons here).
  task automatic run_scan(input bit poke, output bit got, output int lat,
                          output logic rx_after, output logic busy_run, output res_t obs);
    int   best = 0;
    int   s;
    bit   f = 0;
    int   mx = 0, my = 0, bx = 0, by = 0;
    res_t e;
    for (int i = 0; i < win_q.size(); i++) begin
      s = sad_model(make_win(win_q[i], ramp_mode));
      if (!f || s < best) begin
        best = s; bx = mx; by = my; f = 1;
      end
      if (mx == 64) begin
        mx = 0;
        my = (my == 64) ? 0 : my + 1;
      end else mx++;
    end
    e.sad = f ? 16'(best) : 16'hFFFF;
    e.x   = 7'(bx);
    e.y   = 7'(by);
    exp_q.push_back(e);

    start = 1'b1;
    tick();
    start = 1'b0;
    busy_run = busy;
    rx_after = 1'b0;
    if (poke) begin
      tmpl_we = 1'b1; tmpl_addr = 6'd0; tmpl_data = '1; start = 1'b1;
      tick();
      tmpl_we = 1'b0; tmpl_data = '0; start = 1'b0;
    end
    if (win_q.size() == 0) begin
      done = 1'b1;
      tick();
      done = 1'b0;
    end else begin
      for (int i = 0; i < win_q.size(); i++) begin
        window_data  = make_win(win_q[i], ramp_mode);
        window_ready = 1'b1;
        done         = (i == win_q.size() - 1);
        tick();
        if (i == 0) rx_after = receive;
      end
      window_ready = 1'b0;
      done         = 1'b0;
    end
    got = 0;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      if (result_valid === 1'b1) begin
        got = 1; lat = k; break;
      end
      tick();
    end
    obs = {best_sad, best_x, best_y};
  endtask

  task automatic ack_result();
    result_ack = 1'b1;
    tick();
    result_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    checks++; if (receive !== 1'b0) begin errors++; $display("FAIL reset_receive got %b want 0", receive); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL reset_result_valid got %b want 0", result_valid); end
    checks++; if (best_sad !== 16'hFFFF) begin errors++; $display("FAIL reset_best_sad got %h want ffff", best_sad); end
    checks++; if (best_x !== 7'd0) begin errors++; $display("FAIL reset_best_x got %0d want 0", best_x); end
    checks++; if (best_y !== 7'd0) begin errors++; $display("FAIL reset_best_y got %0d want 0", best_y); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    bit got; int lat; logic rx1, bz; res_t obs, e; int rx0;
    write_tmpl(0, 8'h10);
    ramp_mode = 0; win_q = {8'h10};
    rx0 = rx_total;
    run_scan(0, got, lat, rx1, bz, obs);
    e = exp_q.pop_front();
    checks++; if (bz !== 1'b1) begin errors++; $display("FAIL single_busy got %b want 1", bz); end
    checks++; if (rx1 !== 1'b1) begin errors++; $display("FAIL single_receive_t1 got %b want 1", rx1); end
    checks++; if (rx_total - rx0 != 1) begin errors++; $display("FAIL single_rx_count got %0d want 1", rx_total - rx0); end
    checks++; if (!got || lat != 3) begin errors++; $display("FAIL single_latency got %0d (seen %0d) want 3", lat, got); end
    checks++; if (obs !== e) begin errors++; $display("FAIL single_result got sad=%0d x=%0d y=%0d want sad=%0d x=%0d y=%0d", obs.sad, obs.x, obs.y, e.sad, e.x, e.y); end
    ack_result();
    checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL single_ack_drop got %b want 0", result_valid); end
  endtask

  task automatic test_template_map();
    bit got; int lat; logic rx1, bz; res_t obs, e;
    write_tmpl(1, 8'h00);
    ramp_mode = 1; win_q = {8'h00, 8'h01};
    run_scan(0, got, lat, rx1, bz, obs);
    e = exp_q.pop_front();
    checks++; if (!got || obs !== e) begin errors++; $display("FAIL tmpl_map got sad=%0d x=%0d y=%0d want sad=%0d x=%0d y=%0d", obs.sad, obs.x, obs.y, e.sad, e.x, e.y); end
    ack_result();
    ramp_mode = 0;
  endtask

  task automatic test_back_to_back();
    bit got; int lat; logic rx1, bz; res_t obs, e; int rx0;
    write_tmpl(0, 8'h00);
    win_q = {};
    for (int k = 0; k < 65; k++) win_q.push_back((k == 7) ? 8'h00 : 8'h01);
    rx0 = rx_total;
    run_scan(0, got, lat, rx1, bz, obs);
    e = exp_q.pop_front();
    checks++; if (rx_total - rx0 != 65) begin errors++; $display("FAIL b2b_rx_count got %0d want 65", rx_total - rx0); end
    checks++; if (!got || lat != 3) begin errors++; $display("FAIL b2b_latency got %0d want 3", lat); end
    checks++; if (obs !== e) begin errors++; $display("FAIL b2b_result got sad=%0d x=%0d y=%0d want sad=%0d x=%0d y=%0d", obs.sad, obs.x, obs.y, e.sad, e.x, e.y); end
    ack_result();
  endtask

  task automatic test_tie();
    bit got; int lat; logic rx1, bz; res_t obs, e;
    win_q = {};
    for (int k = 0; k < 12; k++) win_q.push_back((k == 3 || k == 9) ? 8'h01 : 8'h02);
    run_scan(0, got, lat, rx1, bz, obs);
    e = exp_q.pop_front();
    checks++; if (!got || obs !== e) begin errors++; $display("FAIL tie_result got sad=%0d x=%0d y=%0d want sad=%0d x=%0d y=%0d", obs.sad, obs.x, obs.y, e.sad, e.x, e.y); end
    ack_result();
  endtask

  task automatic test_empty_ignored();
    bit got; int lat; logic rx1, bz; res_t obs, e;
    win_q = {};
    run_scan(1, got, lat, rx1, bz, obs);
    e = exp_q.pop_front();
    checks++; if (!got || lat != 3) begin errors++; $display("FAIL empty_latency got %0d want 3", lat); end
    checks++; if (obs !== e) begin errors++; $display("FAIL empty_result got sad=%0d x=%0d y=%0d want sad=%0d x=%0d y=%0d", obs.sad, obs.x, obs.y, e.sad, e.x, e.y); end
    ack_result();
    win_q = {8'h00};
    run_scan(0, got, lat, rx1, bz, obs);
    e = exp_q.pop_front();
    checks++; if (!got || obs !== e) begin errors++; $display("FAIL run_tmpl_we_ignored got sad=%0d want sad=%0d", obs.sad, e.sad); end
    ack_result();
  endtask

  task automatic test_full_scan();
    bit got; int lat; logic rx1, bz; res_t obs, e; int rx0;
    win_q = {};
    for (int k = 0; k < 4225; k++) win_q.push_back((k == 4224) ? 8'h00 : 8'hFF);
    rx0 = rx_total;
    run_scan(0, got, lat, rx1, bz, obs);
    e = exp_q.pop_front();
    checks++; if (rx_total - rx0 != 4225) begin errors++; $display("FAIL full_rx_count got %0d want 4225", rx_total - rx0); end
    checks++; if (!got || obs !== e) begin errors++; $display("FAIL full_result got sad=%0d x=%0d y=%0d want sad=%0d x=%0d y=%0d", obs.sad, obs.x, obs.y, e.sad, e.x, e.y); end
    ack_result();
  endtask

  task automatic test_reset_mid_run();
    bit got; int lat; logic rx1, bz; res_t obs, e; bit seen;
    start = 1'b1; tick(); start = 1'b0;
    window_data = make_win(8'h01, 0);
    window_ready = 1'b1;
    tick(); tick(); tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; window_ready = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b want 0", busy); end
    checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL midrst_result_valid got %b want 0", result_valid); end
    checks++; if (best_sad !== 16'hFFFF) begin errors++; $display("FAIL midrst_best_sad got %h want ffff", best_sad); end
    done = 1'b1; tick(); done = 1'b0;
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      if (result_valid === 1'b1 || busy === 1'b1) seen = 1;
      tick();
    end
    checks++; if (seen) begin errors++; $display("FAIL midrst_done_ignored got activity want none"); end
    win_q = {8'h03};
    run_scan(0, got, lat, rx1, bz, obs);
    e = exp_q.pop_front();
    checks++; if (!got || obs !== e) begin errors++; $display("FAIL midrst_tmpl_kept got sad=%0d want sad=%0d", obs.sad, e.sad); end
    ack_result();
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; window_data = '0; window_ready = 1'b0;
    done = 1'b0; tmpl_we = 1'b0; tmpl_addr = '0; tmpl_data = '0;
    result_ack = 1'b0; ramp_mode = 0;
    test_reset();
    test_single();
    test_template_map();
    test_back_to_back();
    test_tie();
    test_empty_ignored();
    test_full_scan();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/window_sad_matcher.md
# window_sad_matcher

Consumer end of the window stream produced by the window handler: it captures each 16x16 8-bit window on `window_ready` and computes the sum of absolute differences (SAD) against a 16x16 template held in internal registers. It tracks the minimum SAD and its (x, y) window position over one full scan, and reports the best match once the handler signals `done`. It is fully pipelined and accepts one window per clock, matching the handler's back-to-back `window_ready` pulses.

## Interface
- No parameters. Sizes are fixed: 16x16 window, 80x80 image, 65x65 window positions.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: reset, synchronous, active-low.
- `start` input 1: one-cycle pulse that begins a scan; honoured only in IDLE.
- `window_data` input [15:0][15:0][7:0]: `window_data[r][c]` is the pixel at window row r, column c.
- `window_ready` input 1: `window_data` is valid this cycle.
- `done` input 1: one-cycle pulse from the handler when the scan is finished.
- `tmpl_we` input 1: template write strobe; honoured only in IDLE.
- `tmpl_addr` input 6: template word address. Row is `addr[5:2]`; byte k of the word goes to column `4*addr[1:0]+k`.
- `tmpl_data` input 32: template word. Byte k is bits `[8k+7:8k]`.
- `receive` output 1: registered acknowledge of an accepted window.
- `busy` output 1: high in RUN and DRAIN.
- `result_valid` output 1: best-match result is valid; held until acknowledged.
- `result_ack` input 1: consumer has taken the result.
- `best_sad` output 16: minimum SAD found.
- `best_x`, `best_y` output 7 each: window column offset and row offset of the best match.

## Operation
- States are IDLE, RUN, DRAIN and REPORT. Reset enters IDLE.
- IDLE:
  - `tmpl_we` writes one template word per cycle.
  - `start` clears the x/y counters to 0, sets `best_sad`=16'hFFFF and `best_x`=`best_y`=0, clears `found`, and moves to RUN.
- RUN:
  - Each `window_ready` is accepted and tagged with the current (x, y).
  - After tagging, x increments. When x=64, x wraps to 0 and y increments. When y=64 and x wraps, y also wraps to 0; this is not an error.
  - `done` moves to DRAIN. A `window_ready` in the same cycle as `done` is still accepted.
- DRAIN: lasts exactly 2 cycles, then moves to REPORT. `window_ready` is ignored.
- REPORT: `result_valid` is high. `result_ack` returns to IDLE, and `result_valid` drops on the next cycle.
- In any state other than RUN, `window_ready` is ignored and `receive` stays 0.
- In any state other than IDLE, `start` and `tmpl_we` are ignored. The template cannot change mid-scan.
- Pipeline, one new window per cycle:
  - S1: 16 row sums of |w−t|, each 12 bits (max 4080).
  - S2: 16-bit total (max 65280, no overflow).
  - S3: compare against the best so far.
- Update rule: the best is replaced if `found`=0 or total < `best_sad` (strictly less). Ties keep the earliest window in raster order. The first window sets `found`.
- Absolute difference is computed on unsigned 8-bit values, zero-extended before subtraction.
- If no window arrives during a scan, REPORT gives `best_sad`=16'hFFFF and `best_x`=`best_y`=0.
- Template registers are not reset; their contents survive `rst_n`. All other state is reset.

## Timing
- Reset values: `receive`=0, `busy`=0, `result_valid`=0, `best_sad`=16'hFFFF, `best_x`=0, `best_y`=0, state IDLE, x/y counters 0, pipeline valids 0.
- `receive` is 1 in cycle t+1 for a window accepted in cycle t.
- Window accepted in cycle t: S1 registers at the end of t, S2 at the end of t+1, best registers update at the end of t+2. The update is visible from cycle t+3.
- `done` in cycle d: DRAIN covers cycles d+1 and d+2. `result_valid` is first high in cycle d+3, which covers a window accepted in cycle d.
- `best_*` outputs are stable while `result_valid` is high.
- `result_ack` while `result_valid`=0 is ignored. `result_ack` in the first REPORT cycle is legal.
- Synchronous reset mid-RUN clears all pipeline valids. No result is produced, and the next scan needs a fresh `start`.
- A template write in cycle t is visible to windows accepted from cycle t+1, while still in IDLE.

## Test plan
- Write all 64 template words as 32'h10101010. Start, one window of all 8'h10, then `done` → `result_valid` in cycle `done`+3 with `best_sad`=0, `best_x`=0, `best_y`=0.
- Template all 0. Stream 65 windows back-to-back where window k is all 8'h01, except k=7, which is all 8'h00 → `best_sad`=0, `best_x`=7, `best_y`=0. `receive` pulses 65 times.
- Template all 0. Stream 4225 windows of all 8'hFF, except position (x=64, y=64) which is all 8'h00 → `best_sad`=0, `best_x`=64, `best_y`=64. All other SADs are 65280 (no overflow).
- Two windows with equal SAD 256 at x=3 and x=9, with all others higher → `best_x`=3 (tie keeps the first).
- Start then immediately `done` with no windows → `best_sad`=16'hFFFF, `best_x`=`best_y`=0. `tmpl_we` and `start` pulsed during RUN are ignored (template readback via a later SAD is unchanged).
- Assert `rst_n`=0 mid-RUN for one cycle → next cycle `busy`=0 and `result_valid`=0. A following `done` has no effect, and the template is preserved.
